// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - shift-and-add sequential unsigned multiplier with approximate mode
//
// Purpose: multiplies two W-bit unsigned operands over W clock cycles, one
// multiplier bit per cycle.  In approximate mode the partial-product bits in
// the TRUNC least-significant columns are dropped before each add.
//
// Parameters:
//   W      operand width (2..16)
//   OW     product output width (W..2*W)
//   TRUNC  low product columns dropped in approximate mode (0..2*W-1)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       multiplicand / multiplier, unsigned, W bits
//   approx_en  approximate mode select, sampled at acceptance
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   p          product bits [OW-1:0]
//   ovf        some full-product bit at index OW or above is set

module seq_mul #(
  parameter int W     = 4,
  parameter int OW    = 2 * W,
  parameter int TRUNC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          approx_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] p,
  output logic          ovf
);

  localparam int CW = $clog2(W + 1);
  localparam int PW = 2 * W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Columns kept in approximate mode: every column at index TRUNC and above.
  function automatic logic [PW-1:0] keep_mask();
    logic [PW-1:0] m;
    for (int i = 0; i < PW; i++) begin
      m[i] = (i >= TRUNC);
    end
    return m;
  endfunction

  localparam logic [PW-1:0] KEEP = keep_mask();

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          apx_q;
  logic [PW-1:0] acc;

  logic          b_bit;
  logic [PW-1:0] pp;
  logic [PW-1:0] pp_m;
  logic [PW-1:0] acc_nxt;

  // One shift-and-add step: multiplier bit cnt selects (a << cnt).
  always_comb begin
    b_bit   = |(b_q & (W'(1) << cnt));
    pp      = {{W{1'b0}}, a_q} << cnt;
    pp_m    = apx_q ? (pp & KEEP) : pp;
    acc_nxt = b_bit ? (acc + pp_m) : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      apx_q <= 1'b0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            apx_q <= approx_en;
            acc   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          // Last multiplier bit consumed: cnt reaches W on this edge.
          if (cnt == CW'(W - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // acc is frozen here, so p/ovf stay stable under backpressure.
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign p         = acc[OW-1:0];

  generate
    if (OW < PW) begin : g_ovf
      assign ovf = |acc[PW-1:OW];
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - self-checking bench for seq_mul

module tb_seq_mul;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       apx;
    logic [7:0] p;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] p;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, approx_en, out_valid, out_ready, ovf;
  logic [3:0] a, b;
  logic [7:0] p;

  logic       in_valid1, in_ready1, out_valid1, ovf1;
  logic [3:0] a1, b1;
  logic [5:0] p1;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc;
  exp_t sb[$];
  vec_t tbl[9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mul #(.W(4), .OW(8), .TRUNC(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .ovf(ovf)
  );

  seq_mul #(.W(4), .OW(6), .TRUNC(2)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .approx_en(1'b0), .out_valid(out_valid1),
    .out_ready(1'b1), .p(p1), .ovf(ovf1)
  );

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: exact product minus every dropped bit of the partial-product
  // matrix in columns below TRUNC (bit a[k-j]&b[j] has weight 2^k).
  function automatic exp_t model(input int x, input int y, input bit apx);
    exp_t e;
    int   full;
    full = x * y;
    if (apx) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 4; j++) begin
          if (k - j >= 0 && ((x >> (k - j)) & 1) == 1 && ((y >> j) & 1) == 1)
            full -= (1 << k);
        end
      end
    end
    e.p   = 8'(full & 255);
    e.ovf = ((full >> 8) != 0);
    return e;
  endfunction

  // Scoreboard: a result is consumed when out_valid && out_ready at the edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got result p=%0d, expected no output", p);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_p", int'(p), int'(e.p));
        check("sb_ovf", int'(ovf), int'(e.ovf));
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the acceptance edge.
  task automatic issue(input int x, input int y, input bit apx, input exp_t e, input bit push);
    int n;
    a = 4'(x);
    b = 4'(y);
    approx_en = apx;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run6(input int x, input int y, input int ep, input int eo);
    int n;
    a1 = 4'(x);
    b1 = 4'(y);
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ow6_latency", n, 4);
    check("ow6_p", int'(p1), ep);
    check("ow6_ovf", int'(ovf1), eo);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, prev, seen;
    bit   first;
    exp_t e;

    tbl[0] = '{4'd15, 4'd15, 1'b0, 8'hE1, 1'b0};
    tbl[1] = '{4'd15, 4'd15, 1'b1, 8'hDC, 1'b0};
    tbl[2] = '{4'd3,  4'd5,  1'b1, 8'h0C, 1'b0};
    tbl[3] = '{4'd3,  4'd5,  1'b0, 8'h0F, 1'b0};
    tbl[4] = '{4'd0,  4'd9,  1'b0, 8'h00, 1'b0};
    tbl[5] = '{4'd9,  4'd0,  1'b1, 8'h00, 1'b0};
    tbl[6] = '{4'd1,  4'd1,  1'b1, 8'h00, 1'b0};
    tbl[7] = '{4'd15, 4'd1,  1'b1, 8'h0C, 1'b0};
    tbl[8] = '{4'd2,  4'd3,  1'b0, 8'h06, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; approx_en = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_p", int'(p), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_in_ready6", int'(in_ready1), 1);

    // Directed vectors with latency check
    for (int i = 0; i < 9; i++) begin
      e.p = tbl[i].p;
      e.ovf = tbl[i].ovf;
      issue(int'(tbl[i].a), int'(tbl[i].b), tbl[i].apx, e, 1'b1);
      wait_out(lat);
      check("latency", lat, 4);
      @(posedge clk); #1;
      check("idle_after_hs", int'(in_ready), 1);
    end

    // OW=6 instance: wrap-around and overflow
    run6(15, 15, 'h21, 1);
    run6(7, 9, 'h3F, 0);

    // Backpressure in DONE
    out_ready = 1'b0;
    e.p = 8'd30; e.ovf = 1'b0;
    issue(5, 6, 1'b0, e, 1'b1);
    wait_out(lat);
    check("bp_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      approx_en = 1'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      check("bp_p_stable", int'(p), 30);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
    end
    in_valid = 1'b1;
    a = 4'd1; b = 4'd1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_out_valid", int'(out_valid), 0);
    check("bp_no_accept_in_hs", int'(in_ready), 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_idle", int'(in_ready), 1);

    // Reset mid-operation at cnt=2
    e.p = 8'd81; e.ovf = 1'b0;
    issue(9, 9, 1'b0, e, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_p", int'(p), 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("mid_rst_no_out", seen, 0);
    e.p = 8'h06; e.ovf = 1'b0;
    issue(2, 3, 1'b0, e, 1'b1);
    wait_out(lat);
    check("post_rst_latency", lat, 4);
    @(posedge clk); #1;

    // Exhaustive back-to-back, both modes
    first = 1'b1;
    prev = 0;
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          issue(x, y, 1'(m), model(x, y, 1'(m)), 1'b1);
          if (!first) check("issue_interval", acc_cyc - prev, 6);
          first = 1'b0;
          prev = acc_cyc;
        end
      end
    end

    lat = 0;
    while (sb.size() != 0 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
